// File: rtl/spram_ctl.sv
// -----------------------------------------------------------------------------
// spram_ctl
//
// This module is the request/response front end for a single-port RAM wrapper.
// The RAM has a 1-cycle read latency and uses en/wnr/addr/wdata/rdata strobes.
//
// Request side:
//   - A valid/ready request channel is turned into RAM strobes.
//   - Reads are handled separately from writes (see response side).
//
// Response side:
//   - Read data comes back through a 3-entry buffered valid/ready channel.
//   - A consumer can stall without losing RAM output.
//   - Writes produce no response.
//
// Clear sweep (CLR=1):
//   - After reset, the controller writes CLR_VAL to every RAM word.
//   - This takes 2**A cycles, one word per cycle.
//   - No requests are accepted until the sweep finishes.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_vld/rdy     request handshake (transfer on req_vld & req_rdy)
//   req_wnr         1 = write, 0 = read
//   req_addr        word address (A bits)
//   req_wdata       write data (D bits)
//   resp_vld/rdy    read-response handshake
//   resp_rdata      read data (head of the response FIFO)
//   ram_en/wnr      RAM enable / write-not-read
//   ram_addr        RAM address
//   ram_wdata       RAM write data
//   ram_rdata       RAM read data, valid the cycle after a read strobe
//   init_done       high once the controller is accepting traffic
// -----------------------------------------------------------------------------
module spram_ctl #(
  parameter int             A       = 6,
  parameter int             D       = 32,
  parameter bit             CLR     = 1'b1,
  parameter logic [D-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_wnr,
  input  logic [A-1:0] req_addr,
  input  logic [D-1:0] req_wdata,
  output logic         resp_vld,
  input  logic         resp_rdy,
  output logic [D-1:0] resp_rdata,
  output logic         ram_en,
  output logic         ram_wnr,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_wdata,
  input  logic [D-1:0] ram_rdata,
  output logic         init_done
);

  typedef enum logic {
    ST_CLR = 1'b0,   // sweeping CLR_VAL through the RAM
    ST_RUN = 1'b1    // serving client requests
  } state_t;

  localparam int          FIFO_DEPTH = 3;
  localparam logic [1:0]  OUT_MAX    = 2'd3;
  localparam logic [1:0]  PTR_LAST   = 2'(FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [A-1:0]   clr_ptr;

  // A read strobed into the RAM last cycle; its data is on ram_rdata now.
  logic           rd_pend;

  // Reads accepted but not yet popped by the consumer. This count covers both
  // the RAM pipeline stage and the FIFO contents. Capping it at 3 is what
  // keeps the FIFO from ever overflowing.
  logic [1:0]     out_cnt;

  logic [D-1:0]   fifo_mem [FIFO_DEPTH];
  logic [1:0]     wr_ptr;
  logic [1:0]     rd_ptr;
  logic [1:0]     fifo_cnt;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  // req_rdy depends only on registers.
  // There is therefore no combinational path from resp_rdy to req_rdy.
  // A pop frees a slot the cycle after it happens.
  assign req_rdy   = init_done & (out_cnt != OUT_MAX);
  assign accept    = req_vld & req_rdy;
  assign rd_accept = accept & ~req_wnr;
  assign push      = rd_pend;
  assign resp_vld  = (fifo_cnt != 2'd0);
  assign pop       = resp_vld & resp_rdy;
  assign resp_rdata = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // RAM strobe mux
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_wnr   = req_wnr;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    if (state == ST_CLR) begin
      // The FSM sits in ST_CLR while rst is held, so the strobe is gated here.
      // The first sweep write then lands on the first edge after release.
      ram_en    = ~rst;
      ram_wnr   = 1'b1;
      ram_addr  = clr_ptr;
      ram_wdata = CLR_VAL;
    end else begin
      ram_en    = accept;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: clear sweep, then run
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLR ? ST_CLR : ST_RUN;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          clr_ptr <= clr_ptr + A'(1);
          if (&clr_ptr) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline tracking and outstanding count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      out_cnt <= 2'd0;
    end else begin
      rd_pend <= rd_accept;
      case ({rd_accept, pop})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (circular, 3 entries, head drives resp_rdata)
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset along with the pointers. It is only three
  // words, and resetting it guarantees resp_rdata reads zero in reset
  // instead of stale or unknown data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_rdata;
        wr_ptr           <= (wr_ptr == PTR_LAST) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? 2'd0 : rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  // The outstanding limit must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == 2'd3));

  // The outstanding count always equals pipeline stage plus FIFO occupancy.
  a_out_consistent: assert property (@(posedge clk) disable iff (rst)
    out_cnt == fifo_cnt + 2'(rd_pend));

endmodule

// File: tb/tb_spram_ctl.sv
// -----------------------------------------------------------------------------
// tb_spram_ctl
//
// This bench drives spram_ctl with a RAM model attached.
//   - A=4, CLR=1, CLR_VAL=32'hDEAD_BEEF.
//
// The reference model is deliberately abstract:
//   - An array holds the architectural memory contents.
//   - A queue holds the read responses the client is still owed.
//   - Each queued response carries the earliest cycle it may appear.
// -----------------------------------------------------------------------------
module tb_spram_ctl;

  localparam int             A     = 4;
  localparam int             D     = 32;
  localparam int             DEPTH = 1 << A;
  localparam logic [D-1:0]   CV    = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic         req_wnr = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [D-1:0] req_wdata = '0;
  logic         resp_vld;
  logic         resp_rdy = 1'b0;
  logic [D-1:0] resp_rdata;
  logic         ram_en;
  logic         ram_wnr;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_wdata;
  logic [D-1:0] ram_rdata;
  logic         init_done;

  always #5 clk = ~clk;

  spram_ctl #(.A(A), .D(D), .CLR(1'b1), .CLR_VAL(CV)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wnr(req_wnr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_rdata(resp_rdata),
    .ram_en(ram_en), .ram_wnr(ram_wnr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .init_done(init_done)
  );

  // Single-port RAM with 1-cycle read latency.
  logic [D-1:0] ram_store [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wnr) ram_store[ram_addr] <= ram_wdata;
      else         ram_rdata <= ram_store[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [D-1:0] data;
    int           ready_at;
  } exp_t;

  exp_t         exp_q[$];
  logic [D-1:0] ref_mem [DEPTH];
  bit           model_ready = 1'b0;
  int           edge_n = 0;
  int           errors = 0;
  int           checks = 0;

  // Observations and model expectations for the most recent tick.
  logic         o_req_rdy, o_resp_vld, o_acc, o_pop;
  logic [D-1:0] o_rdata;
  logic         e_req_rdy, e_resp_vld;
  logic [D-1:0] e_rdata;

  // One clock cycle: drive inputs, sample mid-cycle, then update the model
  // with whatever handshakes the edge completed.
  task automatic tick(input logic vld, input logic wnr, input logic [A-1:0] addr,
                      input logic [D-1:0] wd, input logic rdy);
    exp_t e;
    req_vld = vld; req_wnr = wnr; req_addr = addr; req_wdata = wd; resp_rdy = rdy;
    #1;
    o_req_rdy  = req_rdy;
    o_resp_vld = resp_vld;
    o_rdata    = resp_rdata;
    e_req_rdy  = model_ready && (exp_q.size() < 3);
    e_resp_vld = (exp_q.size() > 0) && (exp_q[0].ready_at <= edge_n);
    e_rdata    = (exp_q.size() > 0) ? exp_q[0].data : '0;
    o_acc      = vld & req_rdy;
    o_pop      = resp_vld & rdy;
    @(posedge clk);
    edge_n++;
    if (o_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (o_acc) begin
      if (wnr) ref_mem[addr] = wd;
      else begin
        // Data is fixed at acceptance; the response is visible after the next edge.
        e.data     = ref_mem[addr];
        e.ready_at = edge_n + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b0, '0, '0, rdy);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    model_ready = 1'b0;
    exp_q.delete();
    idle(1'b1);
    idle(1'b1);
    checks++; if (req_rdy !== 1'b0)    begin errors++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
    checks++; if (resp_vld !== 1'b0)   begin errors++; $display("FAIL reset_resp_vld got=%b exp=0", resp_vld); end
    checks++; if (ram_en !== 1'b0)     begin errors++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
    checks++; if (init_done !== 1'b0)  begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (resp_rdata !== '0)   begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
  endtask

  // Release reset and follow a full sweep; called at a negedge with rst high.
  task automatic run_sweep(input string tag);
    int bad = 0;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (ram_en !== 1'b1 || ram_wnr !== 1'b1 || ram_addr !== A'(i) ||
          ram_wdata !== CV || req_rdy !== 1'b0 || init_done !== 1'b0 || resp_vld !== 1'b0) begin
        bad++;
        $display("FAIL %s_sweep_cycle%0d got en=%b wnr=%b addr=%0d wdata=%h rdy=%b done=%b vld=%b exp 1 1 %0d %h 0 0 0",
                 tag, i, ram_en, ram_wnr, ram_addr, ram_wdata, req_rdy, init_done, resp_vld, i, CV);
      end
      idle(1'b1);
    end
    checks++; if (bad != 0) errors++;
    checks++; if (init_done !== 1'b1 || req_rdy !== 1'b1 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_sweep_end got done=%b rdy=%b en=%b exp 1 1 0", tag, init_done, req_rdy, ram_en);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
    model_ready = 1'b1;
  endtask

  task automatic test_read_after_sweep();
    tick(1'b1, 1'b0, 4'd7, '0, 1'b1);
    checks++; if (o_acc !== 1'b1) begin errors++; $display("FAIL sweep_rd7_accept got=%b exp=1", o_acc); end
    idle(1'b1);
    checks++; if (o_resp_vld !== 1'b0) begin errors++; $display("FAIL sweep_rd7_early got=%b exp=0", o_resp_vld); end
    idle(1'b1);
    checks++; if (o_resp_vld !== 1'b1 || o_rdata !== CV) begin
      errors++; $display("FAIL sweep_rd7_data got vld=%b data=%h exp 1 %h", o_resp_vld, o_rdata, CV);
    end
    idle(1'b1);
  endtask

  task automatic test_write_read();
    tick(1'b1, 1'b1, 4'd5, 32'h1234_5678, 1'b1);
    tick(1'b1, 1'b0, 4'd5, '0, 1'b1);
    checks++; if (o_acc !== 1'b1) begin errors++; $display("FAIL wr_rd_accept got=%b exp=1", o_acc); end
    idle(1'b1);
    checks++; if (o_resp_vld !== 1'b0) begin errors++; $display("FAIL wr_rd_early got=%b exp=0", o_resp_vld); end
    idle(1'b1);
    checks++; if (o_resp_vld !== 1'b1 || o_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_rd_data got vld=%b data=%h exp 1 12345678", o_resp_vld, o_rdata);
    end
    idle(1'b1);
  endtask

  logic [D-1:0] bb [8];

  task automatic test_back_to_back();
    logic [D-1:0] got[$];
    int           first_t = -1;
    int           last_t = -1;
    int           rdy_drop = 0;
    for (int i = 0; i < 8; i++) begin
      bb[i] = $urandom;
      tick(1'b1, 1'b1, A'(i), bb[i], 1'b1);
    end
    for (int t = 0; t < 14; t++) begin
      if (t < 8) tick(1'b1, 1'b0, A'(t), '0, 1'b1);
      else       idle(1'b1);
      if (t < 8 && o_req_rdy !== 1'b1) rdy_drop++;
      if (o_resp_vld) begin
        got.push_back(o_rdata);
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    checks++; if (rdy_drop != 0) begin errors++; $display("FAIL b2b_req_rdy_drops got=%0d exp=0", rdy_drop); end
    checks++; if (got.size() != 8 || first_t != 2 || last_t != 9) begin
      errors++; $display("FAIL b2b_timing got n=%0d first=%0d last=%0d exp 8 2 9", got.size(), first_t, last_t);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== bb[i]) begin
        errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, bb[i]);
      end
    end
  endtask

  task automatic test_stall();
    int           acc = 0;
    logic [D-1:0] got[$];
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, A'(i), '0, 1'b0);
      if (o_acc) acc++;
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL stall_accepted got=%0d exp=3", acc); end
    checks++; if (o_req_rdy !== 1'b0) begin errors++; $display("FAIL stall_req_rdy got=%b exp=0", o_req_rdy); end
    for (int d = 0; d < 5; d++) begin
      idle(1'b1);
      if (d == 0) begin
        checks++; if (o_req_rdy !== 1'b0 || o_pop !== 1'b1) begin
          errors++; $display("FAIL stall_first_pop got rdy=%b pop=%b exp 0 1", o_req_rdy, o_pop);
        end
      end
      if (d == 1) begin
        checks++; if (o_req_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_return got=%b exp=1", o_req_rdy); end
      end
      if (o_resp_vld) got.push_back(o_rdata);
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_resp_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== bb[i]) begin errors++; $display("FAIL stall_data%0d got=%h exp=%h", i, got[i], bb[i]); end
    end
  endtask

  task automatic test_war();
    logic [D-1:0] got[$];
    logic [3:0]   vld_t = 4'b1111;
    logic [3:0]   wnr_t = 4'b0101;
    logic [D-1:0] wd_t [4];
    wd_t[0] = 32'hA; wd_t[1] = '0; wd_t[2] = 32'hB; wd_t[3] = '0;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) tick(vld_t[t], wnr_t[t], 4'd3, wd_t[t], 1'b1);
      else       idle(1'b1);
      if (o_resp_vld) got.push_back(o_rdata);
    end
    checks++; if (got.size() != 2 || got[0] !== 32'hA || got[1] !== 32'hB) begin
      errors++; $display("FAIL war_order got n=%0d first=%h second=%h exp 2 0000000a 0000000b",
                         got.size(), (got.size() > 0) ? got[0] : '0, (got.size() > 1) ? got[1] : '0);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, A'($urandom_range(0, DEPTH - 1)),
           $urandom, $urandom_range(0, 3) != 0);
      if (o_req_rdy !== e_req_rdy || o_resp_vld !== e_resp_vld || (e_resp_vld && o_rdata !== e_rdata)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL rand_cycle%0d got rdy=%b vld=%b data=%h exp %b %b %h",
                   n, o_req_rdy, o_resp_vld, o_rdata, e_req_rdy, e_resp_vld, e_rdata);
      end
    end
    checks++; if (bad != 0) errors++;
    for (int n = 0; n < 8; n++) idle(1'b1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got=%0d exp=0 pending", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    // Two responses parked in the FIFO, then reset.
    tick(1'b1, 1'b0, 4'd1, '0, 1'b0);
    tick(1'b1, 1'b0, 4'd2, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL rstmid_queued got=%b exp=1", resp_vld); end
    rst = 1'b1;
    #1;
    checks++; if (resp_vld !== 1'b0 || req_rdy !== 1'b0 || init_done !== 1'b0 || resp_rdata !== '0) begin
      errors++; $display("FAIL rstmid_async got vld=%b rdy=%b done=%b data=%h exp 0 0 0 0",
                         resp_vld, req_rdy, init_done, resp_rdata);
    end
    exp_q.delete();
    model_ready = 1'b0;
    idle(1'b1);
    // Start a sweep and abort it at clr_ptr = 9.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) idle(1'b1);
    #1;
    checks++; if (ram_addr !== 4'd9 || ram_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_ptr9 got addr=%0d en=%b exp 9 1", ram_addr, ram_en);
    end
    rst = 1'b1;
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rstmid_sweep_en got=%b exp=0", ram_en); end
    idle(1'b1);
    run_sweep("rstmid");
    for (int n = 0; n < 4; n++) begin
      idle(1'b1);
      if (o_resp_vld !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
    tick(1'b1, 1'b0, 4'd1, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++; if (o_resp_vld !== 1'b1 || o_rdata !== CV) begin
      errors++; $display("FAIL rstmid_reread got vld=%b data=%h exp 1 %h", o_resp_vld, o_rdata, CV);
    end
    idle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    run_sweep("init");
    test_read_after_sweep();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_war();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
